// File: rtl/seq_shift_pkg.sv
// seq_shift_pkg: shared types and constants for the sequential shift unit.
// Operation and FSM enums plus the raw-op decoder.
package seq_shift_pkg;

   localparam int WIDTH   = 32;
   localparam int SHAMT_W = 5;

   typedef enum logic [2:0] {
      OP_SHL  = 3'd0,
      OP_SLR  = 3'd1,
      OP_SAR  = 3'd2,
      OP_ROR  = 3'd3,
      OP_ROL  = 3'd4,
      OP_PASS = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Codes 101..111 all collapse onto PASS.
   function automatic op_e op_decode(input logic [2:0] raw);
      return (raw > 3'd4) ? OP_PASS : op_e'(raw);
   endfunction

endpackage

// File: rtl/seq_shift_if.sv
// seq_shift_if: start/busy/done request bus of the shift unit.
// master issues requests, slave is the shift unit.
interface seq_shift_if;
   import seq_shift_pkg::*;

   logic               start;
   logic [2:0]         op;
   logic [SHAMT_W-1:0] amount;
   logic [WIDTH-1:0]   operand;
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   result;
   logic               carry;

   modport master (
      output start, op, amount, operand,
      input  busy, done, result, carry
   );

   modport slave (
      input  start, op, amount, operand,
      output busy, done, result, carry
   );

endinterface

// File: rtl/seq_shift_step.sv
// seq_shift_step: combinational single step of 1 or 4 bit positions.
// carry is the last single bit moved out of the register.
module seq_shift_step
   import seq_shift_pkg::*;
(
   input  op_e              op,
   input  logic [WIDTH-1:0] value,
   input  logic             step4,
   output logic [WIDTH-1:0] next,
   output logic             carry
);

   always_comb begin
      next  = value;
      carry = 1'b0;
      unique case (op)
         OP_SHL: begin
            next  = step4 ? (value << 4) : (value << 1);
            carry = step4 ? value[WIDTH-4] : value[WIDTH-1];
         end
         OP_SLR: begin
            next  = step4 ? (value >> 4) : (value >> 1);
            carry = step4 ? value[3] : value[0];
         end
         OP_SAR: begin
            next  = step4 ? {{4{value[WIDTH-1]}}, value[WIDTH-1:4]}
                          : {value[WIDTH-1], value[WIDTH-1:1]};
            carry = step4 ? value[3] : value[0];
         end
         OP_ROR: begin
            next  = step4 ? {value[3:0], value[WIDTH-1:4]}
                          : {value[0], value[WIDTH-1:1]};
            carry = step4 ? value[3] : value[0];
         end
         OP_ROL: begin
            next  = step4 ? {value[WIDTH-5:0], value[WIDTH-1:WIDTH-4]}
                          : {value[WIDTH-2:0], value[WIDTH-1]};
            carry = step4 ? value[WIDTH-4] : value[WIDTH-1];
         end
         OP_PASS: begin
            next  = value;
            carry = 1'b0;
         end
         default: begin
            next  = value;
            carry = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle shift/rotate unit, FSM + counter + registers.
// Define SEQ_SHIFT_STEP4_EN to move four bits per cycle while count>=4.
module seq_shift_unit
   import seq_shift_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   seq_shift_if.slave bus
);

   state_e             state_q, state_d;
   op_e                op_q, op_in;
   logic [WIDTH-1:0]   reg_q, reg_d, res_q, step_val;
   logic [SHAMT_W-1:0] cnt_q, cnt_d, dec;
   logic               car_q, car_d, step_car, big;

   assign op_in = op_decode(bus.op);

`ifdef SEQ_SHIFT_STEP4_EN
   assign big = (cnt_q >= SHAMT_W'(4));
`else
   assign big = 1'b0;
`endif

   assign dec = big ? SHAMT_W'(4) : SHAMT_W'(1);

   seq_shift_step u_step (
      .op    (op_q),
      .value (reg_q),
      .step4 (big),
      .next  (step_val),
      .carry (step_car)
   );

   always_comb begin
      state_d = state_q;
      reg_d   = reg_q;
      cnt_d   = cnt_q;
      car_d   = car_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               reg_d   = bus.operand;
               cnt_d   = bus.amount;
               car_d   = 1'b0;
               state_d = (bus.amount == '0 || op_in == OP_PASS)
                         ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q != '0) begin
               reg_d = step_val;
               car_d = step_car;
               cnt_d = cnt_q - dec;
            end
            // The step that empties the counter is the last one.
            if (cnt_q <= dec) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= OP_PASS;
         reg_q   <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         car_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         reg_q   <= reg_d;
         cnt_q   <= cnt_d;
         car_q   <= car_d;
         if (state_q == IDLE && bus.start) op_q <= op_in;
         if (state_d == DONE && state_q != DONE) res_q <= reg_d;
      end
   end

   assign bus.busy   = (state_q != IDLE);
   assign bus.done   = (state_q == DONE);
   assign bus.result = res_q;
   assign bus.carry  = car_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit: directed and random checks against an arithmetic model.
// Honours SEQ_SHIFT_STEP4_EN for the expected latency.
module tb_seq_shift_unit;

`ifdef SEQ_SHIFT_STEP4_EN
   localparam int L31 = 11;
   localparam int L10 = 5;
`else
   localparam int L31 = 32;
   localparam int L10 = 11;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cmp_en = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   done_cnt = 0;

   seq_shift_if bus ();

   seq_shift_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Whole-operation model: {carry, result} straight from shift arithmetic.
   function automatic logic [32:0] ref_shift(input logic [2:0] op,
                                             input int a,
                                             input logic [31:0] x);
      logic [31:0] r;
      logic        c;
      if (a == 0 || op > 3'd4) return {1'b0, x};
      case (op)
         3'd0: begin r = x << a; c = x[32-a]; end
         3'd1: begin r = x >> a; c = x[a-1]; end
         3'd2: begin r = 32'($signed(x) >>> a); c = x[a-1]; end
         3'd3: begin r = (x >> a) | (x << (32-a)); c = x[a-1]; end
         default: begin r = (x << a) | (x >> (32-a)); c = x[32-a]; end
      endcase
      return {c, r};
   endfunction

   function automatic int latency(input logic [2:0] op, input int a);
      if (a == 0 || op > 3'd4) return 1;
`ifdef SEQ_SHIFT_STEP4_EN
      return a / 4 + a % 4 + 1;
`else
      return a + 1;
`endif
   endfunction

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   logic        m_busy = 1'b0, m_done = 1'b0, m_carry = 1'b0;
   logic [31:0] m_result = '0;
   logic [32:0] pend = '0;
   int          m_left = 0;

   // Cycle model: countdown to the done cycle, answer precomputed at start.
   always begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_busy = 0; m_done = 0; m_result = '0; m_carry = 0; m_left = 0;
      end else if (m_done) begin
         m_done = 0; m_busy = 0;
      end else if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_done = 1; m_result = pend[31:0]; m_carry = pend[32];
         end
      end else if (bus.start) begin
         pend    = ref_shift(bus.op, int'(bus.amount), bus.operand);
         m_left  = latency(bus.op, int'(bus.amount)) - 1;
         m_busy  = 1;
         m_carry = 0;
         if (m_left == 0) begin
            m_done = 1; m_result = pend[31:0]; m_carry = pend[32];
         end
      end
   end

   always begin
      @(negedge clk);
      if (cmp_en) begin
         check("busy", 64'(bus.busy), 64'(m_busy));
         check("done", 64'(bus.done), 64'(m_done));
         if (m_done || !m_busy) begin
            check("result", 64'(bus.result), 64'(m_result));
            check("carry", 64'(bus.carry), 64'(m_carry));
         end
      end
   end

   always begin
      @(posedge clk);
      if (bus.done) done_cnt++;
   end

   task automatic run(input logic [2:0] o, input int a, input logic [31:0] x,
                      input logic [31:0] er, input logic ec, input int el,
                      input int pulse, input string nm);
      logic [32:0] m;
      int cyc, d0;
      m = ref_shift(o, a, x);
      check({nm, " model"}, 64'(m), 64'({ec, er}));
      d0 = done_cnt;
      bus.start = 1; bus.op = o; bus.amount = 5'(a); bus.operand = x;
      @(negedge clk);
      bus.start = 0;
      bus.op = 3'($urandom); bus.amount = 5'($urandom); bus.operand = $urandom;
      cyc = 1;
      while (!bus.done && cyc < 64) begin
         if (cyc == pulse) bus.start = 1;
         @(negedge clk);
         bus.start = 0;
         cyc++;
      end
      check({nm, " latency"}, 64'(cyc), 64'(el));
      check({nm, " result"}, 64'(bus.result), 64'(er));
      check({nm, " carry"}, 64'(bus.carry), 64'(ec));
      repeat (4) @(negedge clk);
      check({nm, " done pulses"}, 64'(done_cnt - d0), 64'd1);
   endtask

   initial begin
      int d0, r;
      bus.start = 0; bus.op = '0; bus.amount = '0; bus.operand = '0;
      repeat (3) @(negedge clk);
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset done", 64'(bus.done), 64'd0);
      check("reset result", 64'(bus.result), 64'd0);
      check("reset carry", 64'(bus.carry), 64'd0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      cmp_en = 1'b1;

      run(3'd0, 2, 32'h4000_0001, 32'h0000_0004, 1'b1, 3, 0, "shl2");
      run(3'd3, 2, 32'h4000_0001, 32'h5000_0000, 1'b0, 3, 0, "ror2");
      run(3'd4, 1, 32'h8000_0001, 32'h0000_0003, 1'b1, 2, 0, "rol1");
      run(3'd2, 31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, L31, 0, "sar31");
      run(3'd1, 31, 32'h8000_0000, 32'h0000_0001, 1'b0, L31, 0, "slr31");
      run(3'd0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1, 0, "amt0");
      run(3'd6, 7, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1, 0, "pass");
      run(3'd1, 10, 32'hF000_0A00, 32'h003C_0002, 1'b1, L10, 2, "slr10 restart");

      // Asynchronous abort in the middle of a long shift.
      bus.start = 1; bus.op = 3'd0; bus.amount = 5'd20; bus.operand = 32'hFFFF_FFFF;
      @(negedge clk);
      bus.start = 0;
      repeat (4) @(negedge clk);
      d0 = done_cnt;
      #2 rst_n = 1'b0;
      #1;
      check("abort busy", 64'(bus.busy), 64'd0);
      check("abort done", 64'(bus.done), 64'd0);
      check("abort result", 64'(bus.result), 64'd0);
      check("abort carry", 64'(bus.carry), 64'd0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (25) @(negedge clk);
      check("abort no done", 64'(done_cnt - d0), 64'd0);
      run(3'd4, 31, 32'h0000_0001, 32'h8000_0000, 1'b0, L31, 0, "rol31");

      for (int i = 0; i < 600; i++) begin
         r = int'($urandom_range(7, 0));
         bus.start   = ($urandom_range(2, 0) == 0);
         bus.op      = 3'($urandom);
         bus.amount  = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : 5'($urandom);
         bus.operand = $urandom;
         @(negedge clk);
      end
      bus.start = 0;
      repeat (40) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
